// File: rtl/mig1_mem_arbiter.sv
// rtl/mig1_mem_arbiter.sv - round-robin arbiter sharing the Mig1 SimRAM between fetch and data paths
module mig1_mem_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_valid,
  output logic                  if_req_ready,
  input  logic [ADDR_WIDTH-1:0] if_req_addr,
  output logic                  if_rsp_valid,
  output logic [DATA_WIDTH-1:0] if_rsp_data,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic                  d_req_we,
  input  logic [ADDR_WIDTH-1:0] d_req_addr,
  input  logic [DATA_WIDTH-1:0] d_req_wdata,
  output logic                  d_rsp_valid,
  output logic [DATA_WIDTH-1:0] d_rsp_data,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  busy
);

  localparam int CW = $clog2(RD_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic                   owner_q;       // 1 = data port
  logic                   last_grant_q;  // 1 = data port
  logic                   if_rsp_valid_q;
  logic                   d_rsp_valid_q;
  logic [DATA_WIDTH-1:0]  if_rsp_data_q;
  logic [DATA_WIDTH-1:0]  d_rsp_data_q;

  logic idle_d;
  logic grant_if_d;
  logic grant_d_d;

  // rst gates the grant so readies and RAM enables drop with reset, not at the next edge
  assign idle_d     = (state_q == IDLE) && !rst;
  assign grant_if_d = idle_d && if_req_valid && (!d_req_valid || last_grant_q);
  assign grant_d_d  = idle_d && d_req_valid && !grant_if_d;

  assign if_req_ready = grant_if_d;
  assign d_req_ready  = grant_d_d;

  assign ram_rd_en   = grant_if_d || (grant_d_d && !d_req_we);
  assign ram_rd_addr = grant_if_d ? if_req_addr :
                       (grant_d_d && !d_req_we) ? d_req_addr : '0;
  assign ram_wr_en   = grant_d_d && d_req_we;
  assign ram_wr_addr = ram_wr_en ? d_req_addr : '0;
  assign ram_wr_data = ram_wr_en ? d_req_wdata : '0;

  assign if_rsp_valid = if_rsp_valid_q;
  assign if_rsp_data  = if_rsp_data_q;
  assign d_rsp_valid  = d_rsp_valid_q;
  assign d_rsp_data   = d_rsp_data_q;
  assign busy         = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      owner_q        <= 1'b0;
      last_grant_q   <= 1'b1;
      if_rsp_valid_q <= 1'b0;
      d_rsp_valid_q  <= 1'b0;
      if_rsp_data_q  <= '0;
      d_rsp_data_q   <= '0;
    end else begin
      if_rsp_valid_q <= 1'b0;
      d_rsp_valid_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_if_d || grant_d_d) begin
            owner_q      <= grant_d_d;
            last_grant_q <= grant_d_d;
            if (ram_wr_en) begin
              state_q       <= RESP;
              d_rsp_valid_q <= 1'b1;
              d_rsp_data_q  <= '0;
            end else begin
              state_q <= RD_WAIT;
              cnt_q   <= CW'(RD_LATENCY - 1);
            end
          end
        end
        RD_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= RESP;
            if (owner_q) begin
              d_rsp_valid_q <= 1'b1;
              d_rsp_data_q  <= ram_rd_data;
            end else begin
              if_rsp_valid_q <= 1'b1;
              if_rsp_data_q  <= ram_rd_data;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mig1_mem_arbiter.sv
// tb/tb_mig1_mem_arbiter.sv - scoreboard bench for mig1_mem_arbiter (RD_LATENCY 1 and 3 instances)
module tb_mig1_mem_arbiter;
  localparam int LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main DUT (RD_LATENCY=1)
  logic        if_v = 0, d_v = 0, d_we = 0;
  logic [7:0]  if_a = 0, d_a = 0;
  logic [31:0] d_wd = 0;
  logic        if_req_ready, if_rsp_valid, d_req_ready, d_rsp_valid;
  logic [31:0] if_rsp_data, d_rsp_data, ram_rd_data, ram_wr_data;
  logic        ram_rd_en, ram_wr_en, busy;
  logic [7:0]  ram_rd_addr, ram_wr_addr;

  mig1_mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .RD_LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_v), .if_req_ready(if_req_ready), .if_req_addr(if_a),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .d_req_valid(d_v), .d_req_ready(d_req_ready), .d_req_we(d_we),
    .d_req_addr(d_a), .d_req_wdata(d_wd),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .busy(busy)
  );

  // second DUT (RD_LATENCY=3), directed only
  logic        x_if_v = 0, x_d_v = 0;
  logic [7:0]  x_if_a = 0, x_d_a = 0;
  logic        x_if_ready, x_if_rsp_valid, x_d_ready, x_d_rsp_valid;
  logic [31:0] x_if_rsp_data, x_d_rsp_data, x_rd_data, x_wr_data;
  logic        x_rd_en, x_wr_en, x_busy;
  logic [7:0]  x_rd_addr, x_wr_addr;

  mig1_mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .RD_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .if_req_valid(x_if_v), .if_req_ready(x_if_ready), .if_req_addr(x_if_a),
    .if_rsp_valid(x_if_rsp_valid), .if_rsp_data(x_if_rsp_data),
    .d_req_valid(x_d_v), .d_req_ready(x_d_ready), .d_req_we(1'b0),
    .d_req_addr(x_d_a), .d_req_wdata(32'h0),
    .d_rsp_valid(x_d_rsp_valid), .d_rsp_data(x_d_rsp_data),
    .ram_rd_en(x_rd_en), .ram_rd_addr(x_rd_addr), .ram_rd_data(x_rd_data),
    .ram_wr_en(x_wr_en), .ram_wr_addr(x_wr_addr), .ram_wr_data(x_wr_data),
    .busy(x_busy)
  );

  // RAM models: word-indexed, initial contents from init_mem until written
  logic [31:0] init_mem [64];
  logic [31:0] mem [64];
  logic [63:0] written = '0;
  logic [31:0] rd_q = 0;
  assign ram_rd_data = rd_q;
  always @(posedge clk) begin
    if (ram_wr_en) begin
      mem[ram_wr_addr[7:2]]     <= ram_wr_data;
      written[ram_wr_addr[7:2]] <= 1'b1;
    end
    if (ram_rd_en)
      rd_q <= written[ram_rd_addr[7:2]] ? mem[ram_rd_addr[7:2]] : init_mem[ram_rd_addr[7:2]];
  end

  logic [31:0] p0 = 0, p1 = 0, p2 = 0;
  assign x_rd_data = p2;
  always @(posedge clk) begin
    if (x_rd_en) p0 <= init_mem[x_rd_addr[7:2]];
    p1 <= p0;
    p2 <= p1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // reference model: predicts grants, RAM strobes and responses
  typedef struct {bit owner; logic [31:0] data; int due;} exp_t;
  exp_t q[$];
  logic [31:0] ref_wr [int];
  bit m_last = 1'b1;
  int m_free = 0;

  function automatic logic [31:0] ref_rd(input logic [7:0] a);
    int i = int'(a[7:2]);
    return ref_wr.exists(i) ? ref_wr[i] : init_mem[i];
  endfunction

  always @(negedge clk) begin
    bit gi, gd, eb;
    if (rst) begin
      q.delete();
      m_last = 1'b1;
      m_free = 0;
      chk("rst_if_ready", {31'b0, if_req_ready}, 0);
      chk("rst_d_ready", {31'b0, d_req_ready}, 0);
      chk("rst_enables", {30'b0, ram_rd_en, ram_wr_en}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
    end else begin
      eb = (cyc < m_free);
      chk("busy", {31'b0, busy}, {31'b0, eb});
      gi = !eb && if_v && (!d_v || m_last);
      gd = !eb && d_v && !gi;
      chk("if_ready", {31'b0, if_req_ready}, {31'b0, gi});
      chk("d_ready", {31'b0, d_req_ready}, {31'b0, gd});
      if (gi || (gd && !d_we)) begin
        chk("rd_en", {31'b0, ram_rd_en}, 1);
        chk("rd_addr", {24'b0, ram_rd_addr}, {24'b0, gi ? if_a : d_a});
        chk("wr_en_on_rd", {31'b0, ram_wr_en}, 0);
        q.push_back('{owner: gd, data: ref_rd(gi ? if_a : d_a), due: cyc + LAT + 1});
        m_free = cyc + LAT + 2;
        m_last = gd;
      end else if (gd) begin
        chk("wr_en", {31'b0, ram_wr_en}, 1);
        chk("wr_addr", {24'b0, ram_wr_addr}, {24'b0, d_a});
        chk("wr_data", ram_wr_data, d_wd);
        chk("rd_en_on_wr", {31'b0, ram_rd_en}, 0);
        ref_wr[int'(d_a[7:2])] = d_wd;
        q.push_back('{owner: 1'b1, data: 32'h0, due: cyc + 1});
        m_free = cyc + 2;
        m_last = 1'b1;
      end else begin
        chk("idle_enables", {30'b0, ram_rd_en, ram_wr_en}, 0);
      end
    end
  end

  // monitor: pops expectations whenever a response pulse appears
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk("rst_rsp_valid", {30'b0, if_rsp_valid, d_rsp_valid}, 0);
    end else if (if_rsp_valid || d_rsp_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_rsp", {30'b0, if_rsp_valid, d_rsp_valid}, 0);
      end else begin
        e = q.pop_front();
        chk("rsp_single", {31'b0, if_rsp_valid & d_rsp_valid}, 0);
        chk("rsp_owner", {31'b0, d_rsp_valid}, {31'b0, e.owner});
        chk("rsp_cycle", cyc, e.due);
        chk("rsp_data", e.owner ? d_rsp_data : if_rsp_data, e.data);
      end
    end else if (q.size() > 0 && q[0].due < cyc) begin
      chk("rsp_missing", cyc, q[0].due);
      void'(q.pop_front());
    end
  end

  // driver
  bit if_hs, d_hs;

  task automatic step();
    @(negedge clk);
    if_hs = if_v && if_req_ready;
    d_hs  = d_v && d_req_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_if();
    int n = 0;
    do begin step(); n++; end while (!if_hs && n < 40);
    if (!if_hs) chk("if_hs_timeout", 0, 1);
  endtask

  task automatic wait_d();
    int n = 0;
    do begin step(); n++; end while (!d_hs && n < 40);
    if (!d_hs) chk("d_hs_timeout", 0, 1);
  endtask

  task automatic drain();
    if_v = 0;
    d_v = 0;
    repeat (8) step();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) init_mem[i] = $urandom;
    init_mem[4] = 32'hDEADBEEF;

    // reset held with both requesters active
    if_v = 1; if_a = 8'h04; d_v = 1; d_we = 0; d_a = 8'h08;
    repeat (3) step();
    rst = 0;

    // both valid continuously: grants alternate IF, DATA, ...
    for (int k = 0; k < 16; k++) begin
      step();
      if (if_hs) if_a = 8'($urandom);
      if (d_hs) d_a = 8'($urandom);
    end
    drain();

    // fetch 0x10 twice back-to-back: second accept three cycles after the first
    if_v = 1; if_a = 8'h10;
    wait_if();
    wait_if();
    drain();

    // store then load of the same word
    d_v = 1; d_we = 1; d_a = 8'h20; d_wd = 32'h12345678;
    wait_d();
    d_we = 0; d_wd = 0;
    wait_d();
    drain();

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      step();
      if (if_hs || !if_v) begin
        if_v = ($urandom_range(0, 2) != 0);
        if_a = 8'($urandom);
      end
      if (d_hs || !d_v) begin
        d_v  = ($urandom_range(0, 2) != 0);
        d_we = $urandom_range(0, 1);
        d_a  = 8'($urandom);
        d_wd = $urandom;
      end
    end
    drain();

    // reset while a load is in RD_WAIT: response dropped, fetch wins next
    d_v = 1; d_we = 0; d_a = 8'h44;
    wait_d();
    d_v = 0;
    rst = 1;
    #1;
    chk("async_rst_busy", {31'b0, busy}, 0);
    chk("async_rst_rd_en", {31'b0, ram_rd_en}, 0);
    @(posedge clk);
    #1;
    rst = 0;
    if_v = 1; if_a = 8'h50; d_v = 1; d_a = 8'h54;
    step();
    chk("post_rst_if_first", {31'b0, if_hs}, 1);
    if_v = 0;
    wait_d();
    drain();

    // RD_LATENCY=3 instance: load at T0, fetch waiting from T1
    x_d_v = 1; x_d_a = 8'h30;
    @(negedge clk);
    chk("lat3_accept_T0", {31'b0, x_d_ready}, 1);
    @(posedge clk);
    #1;
    x_d_v = 0; x_if_v = 1; x_if_a = 8'h40;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("lat3_busy", {31'b0, x_busy}, {31'b0, k <= 4});
      chk("lat3_if_ready", {31'b0, x_if_ready}, {31'b0, k == 5});
      chk("lat3_d_rsp_valid", {31'b0, x_d_rsp_valid}, {31'b0, k == 4});
      if (k == 4) chk("lat3_d_rsp_data", x_d_rsp_data, init_mem[12]);
      @(posedge clk);
      #1;
    end
    x_if_v = 0;
    repeat (8) @(posedge clk);
    #1;

    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
